// File: rtl/frog_controller.sv
// Frog position, life count and game-over flag for the frogger game; optional macro FROG_GRACE_PERIOD_EN.
// Latency: 1 cycle from sampled switch/collision/reset_* to registered outputs.
// Backpressure: none; switches are edge-detected every cycle, excess edges are dropped.
module frog_controller #(
    parameter int unsigned GRID_W         = 20,
    parameter int unsigned GRID_H         = 15,
    parameter int unsigned START_X        = 10,
    parameter int unsigned RESPAWN_CYCLES = 12_500_000,
    parameter int unsigned GRACE_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debounced_sw1,
    input  logic       debounced_sw2,
    input  logic       debounced_sw3,
    input  logic       debounced_sw4,
    input  logic       collision,
    input  logic       reset_frog,
    input  logic       reset_lives,
    output logic [4:0] frog_x,
    output logic [3:0] frog_y,
    output logic       frog_at_top,
    output logic [1:0] lives,
    output logic       reset_level
);

    // Timer covers the longer of the two freeze/grace windows.
    localparam int unsigned MAX_CYC = (RESPAWN_CYCLES > GRACE_CYCLES) ? RESPAWN_CYCLES : GRACE_CYCLES;
    localparam int unsigned TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [4:0] X_MAX   = 5'(GRID_W - 1);
    localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
    localparam logic [4:0] X_START = 5'(START_X);

    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        AT_TOP    = 3'd1,
        HIT       = 3'd2,
`ifdef FROG_GRACE_PERIOD_EN
        GRACE     = 3'd4,
`endif
        GAME_OVER = 3'd3
    } state_t;

    state_t        state, n_state;
    logic [3:0]    sw_q;
    logic [3:0]    sw;
    logic [3:0]    rise;
    logic [TW-1:0] timer, n_timer;
    logic [4:0]    n_x, mv_x;
    logic [3:0]    n_y, mv_y;
    logic          n_at_top, n_reset_level, mv_vld;
    logic [1:0]    n_lives;

    assign sw   = {debounced_sw4, debounced_sw3, debounced_sw2, debounced_sw1};
    assign rise = sw & ~sw_q;

    // Highest-priority rising switch decides; a blocked move is simply dropped.
    always_comb begin
        mv_vld = 1'b0;
        mv_x   = frog_x;
        mv_y   = frog_y;
        if (!(&sw)) begin
            if (rise[0]) begin
                if (frog_y != 4'd0) begin
                    mv_y   = frog_y - 4'd1;
                    mv_vld = 1'b1;
                end
            end else if (rise[1]) begin
                if (frog_y != Y_MAX) begin
                    mv_y   = frog_y + 4'd1;
                    mv_vld = 1'b1;
                end
            end else if (rise[2]) begin
                if (frog_x != 5'd0) begin
                    mv_x   = frog_x - 5'd1;
                    mv_vld = 1'b1;
                end
            end else if (rise[3]) begin
                if (frog_x != X_MAX) begin
                    mv_x   = frog_x + 5'd1;
                    mv_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_state       = state;
        n_x           = frog_x;
        n_y           = frog_y;
        n_at_top      = frog_at_top;
        n_lives       = lives;
        n_reset_level = reset_level;
        n_timer       = timer;

        if (reset_lives) begin
            n_lives       = 2'd3;
            n_reset_level = 1'b0;
            n_x           = X_START;
            n_y           = Y_MAX;
            n_at_top      = 1'b0;
            n_timer       = '0;
            n_state       = PLAY;
        end else if (reset_frog && state != GAME_OVER) begin
            n_x      = X_START;
            n_y      = Y_MAX;
            n_at_top = 1'b0;
            n_timer  = '0;
            n_state  = PLAY;
        end else begin
            case (state)
                PLAY: begin
                    if (collision) begin
                        n_x = X_START;
                        n_y = Y_MAX;
                        if (lives <= 2'd1) begin
                            n_lives       = 2'd0;
                            n_reset_level = 1'b1;
                            n_state       = GAME_OVER;
                        end else begin
                            n_lives = lives - 2'd1;
                            n_timer = TW'(RESPAWN_CYCLES - 1);
                            n_state = HIT;
                        end
                    end else if (mv_vld) begin
                        n_x = mv_x;
                        n_y = mv_y;
                        if (mv_y == 4'd0) begin
                            n_at_top = 1'b1;
                            n_state  = AT_TOP;
                        end
                    end
                end
                HIT: begin
                    if (timer == '0) begin
`ifdef FROG_GRACE_PERIOD_EN
                        n_timer = TW'(GRACE_CYCLES - 1);
                        n_state = GRACE;
`else
                        n_state = PLAY;
`endif
                    end else begin
                        n_timer = timer - TW'(1);
                    end
                end
`ifdef FROG_GRACE_PERIOD_EN
                GRACE: begin
                    if (timer == '0) begin
                        n_state = PLAY;
                    end else begin
                        n_timer = timer - TW'(1);
                    end
                    if (mv_vld) begin
                        n_x = mv_x;
                        n_y = mv_y;
                        if (mv_y == 4'd0) begin
                            n_at_top = 1'b1;
                            n_timer  = '0;
                            n_state  = AT_TOP;
                        end
                    end
                end
`endif
                AT_TOP:    n_at_top = 1'b1;
                GAME_OVER: begin
                    n_lives       = 2'd0;
                    n_reset_level = 1'b1;
                end
                default:   n_state = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PLAY;
            sw_q        <= 4'd0;
            timer       <= '0;
            frog_x      <= X_START;
            frog_y      <= Y_MAX;
            frog_at_top <= 1'b0;
            lives       <= 2'd3;
            reset_level <= 1'b0;
        end else begin
            state       <= n_state;
            sw_q        <= sw;
            timer       <= n_timer;
            frog_x      <= n_x;
            frog_y      <= n_y;
            frog_at_top <= n_at_top;
            lives       <= n_lives;
            reset_level <= n_reset_level;
        end
    end

endmodule

// File: tb/tb_frog_controller.sv
// Directed bench for frog_controller with short respawn/grace windows.
module tb_frog_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw1, sw2, sw3, sw4;
    logic       collision, reset_frog, reset_lives;
    logic [4:0] frog_x;
    logic [3:0] frog_y;
    logic       frog_at_top;
    logic [1:0] lives;
    logic       reset_level;

    int tests = 0;
    int fails = 0;

    frog_controller #(
        .GRID_W(20), .GRID_H(15), .START_X(10),
        .RESPAWN_CYCLES(8), .GRACE_CYCLES(6)
    ) dut (
        .clk(clk), .reset(reset),
        .debounced_sw1(sw1), .debounced_sw2(sw2),
        .debounced_sw3(sw3), .debounced_sw4(sw4),
        .collision(collision), .reset_frog(reset_frog), .reset_lives(reset_lives),
        .frog_x(frog_x), .frog_y(frog_y), .frog_at_top(frog_at_top),
        .lives(lives), .reset_level(reset_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse a switch mask for one cycle then release for one cycle.
    task automatic press(input logic [3:0] m);
        {sw4, sw3, sw2, sw1} = m;
        step();
        {sw4, sw3, sw2, sw1} = 4'b0000;
        step();
    endtask

    task automatic pulse_rf();
        reset_frog = 1'b1;
        step();
        reset_frog = 1'b0;
    endtask

    task automatic hit();
        collision = 1'b1;
        step();
        collision = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {sw4, sw3, sw2, sw1} = 4'b0000;
        collision = 1'b0; reset_frog = 1'b0; reset_lives = 1'b0;
        step(); step();
        chk("rst_x", frog_x, 10);
        chk("rst_y", frog_y, 14);
        chk("rst_lives", lives, 3);
        chk("rst_top", frog_at_top, 0);
        chk("rst_lvl", reset_level, 0);
        reset = 1'b0;
        step();

        // Single edge, then a long hold gives exactly one move
        sw1 = 1'b1;
        step();
        chk("up1_y", frog_y, 13);
        chk("up1_x", frog_x, 10);
        repeat (99) step();
        chk("hold_y", frog_y, 13);
        sw1 = 1'b0;
        step();

        for (int i = 0; i < 13; i++) press(4'b0001);
        chk("top_y", frog_y, 0);
        chk("top_flag", frog_at_top, 1);
        press(4'b0001);
        press(4'b0010);
        chk("top_hold_y", frog_y, 0);
        chk("top_hold_flag", frog_at_top, 1);
        pulse_rf();
        chk("rf_y", frog_y, 14);
        chk("rf_x", frog_x, 10);
        chk("rf_top", frog_at_top, 0);

        // Bounds and arbitration
        press(4'b0010);
        chk("down_edge_y", frog_y, 14);
        for (int i = 0; i < 10; i++) press(4'b0100);
        chk("left_x0", frog_x, 0);
        press(4'b0100);
        chk("left_edge_x", frog_x, 0);
        for (int i = 0; i < 19; i++) press(4'b1000);
        chk("right_x19", frog_x, 19);
        press(4'b1000);
        chk("right_edge_x", frog_x, 19);
        press(4'b1111);
        chk("all4_x", frog_x, 19);
        chk("all4_y", frog_y, 14);
        press(4'b1100);
        chk("prio_left_x", frog_x, 18);
        press(4'b0101);
        chk("prio_up_y", frog_y, 13);
        chk("prio_up_x", frog_x, 18);
        pulse_rf();

        // Collision: respawn freeze of 8 cycles, move accepted on the 9th
        hit();
        chk("hit_lives", lives, 2);
        chk("hit_x", frog_x, 10);
        chk("hit_y", frog_y, 14);
        for (int k = 1; k <= 8; k++) begin
            sw1 = (k == 4);
            step();
        end
        chk("frozen_y", frog_y, 14);
        sw1 = 1'b1;
        step();
        chk("resume_y", frog_y, 13);
        sw1 = 1'b0;

        // Down to game over
        pulse_rf();
        hit();
        chk("hit2_lives", lives, 1);
        repeat (8) step();
        pulse_rf();
        hit();
        chk("go_lives", lives, 0);
        chk("go_lvl", reset_level, 1);
        press(4'b0001);
        chk("go_move_y", frog_y, 14);
        pulse_rf();
        hit();
        chk("go_rf_lvl", reset_level, 1);
        chk("go_rf_lives", lives, 0);
        reset_lives = 1'b1;
        step();
        reset_lives = 1'b0;
        chk("rl_lives", lives, 3);
        chk("rl_lvl", reset_level, 0);
        press(4'b0001);
        chk("rl_play_y", frog_y, 13);

        // Collision beats a same-cycle move
        sw1 = 1'b1; collision = 1'b1;
        step();
        sw1 = 1'b0; collision = 1'b0;
        chk("coll_win_lives", lives, 2);
        chk("coll_win_y", frog_y, 14);

        // Async reset in the middle of HIT
        repeat (3) step();
        reset = 1'b1;
        #2;
        chk("arst_lives", lives, 3);
        chk("arst_y", frog_y, 14);
        reset = 1'b0;
        step();
        press(4'b0001);
        chk("arst_play_y", frog_y, 13);

`ifdef FROG_GRACE_PERIOD_EN
        pulse_rf();
        hit();
        repeat (8) step();
        hit();
        chk("grace_lives", lives, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frog_controller.md
Name: frog_controller

Overview:
- Owns frog position and the life count. It is the counterpart of the level counter: it produces `frog_at_top`, `lives` and `reset_level`, and responds to `reset_frog` and `reset_lives`.
- Switch edges move the frog on a tile grid. A collision input from the car logic costs a life.
- Grid position feeds the VGA frog renderer.

Parameters:
- GRID_W, 20, grid columns (640 px / 32 px tiles)
- GRID_H, 15, grid rows; row 0 is the top (goal), row GRID_H-1 is the start row
- START_X, 10, spawn column (bottom centre)
- RESPAWN_CYCLES, 12_500_000, cycles frozen after a hit (0.5 s at 25 MHz); must be ≥ 1
- GRACE_CYCLES, 25_000_000, invulnerable cycles after respawn (used only with the optional feature)

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-high reset
- debounced_sw1  in  1  up
- debounced_sw2  in  1  down
- debounced_sw3  in  1  left
- debounced_sw4  in  1  right
- collision  in  1  frog tile overlaps a car (level, synchronous to clk)
- reset_frog  in  1  from level counter: return frog to spawn
- reset_lives  in  1  from level counter: restore lives to 3
- frog_x  out  5  current column
- frog_y  out  4  current row
- frog_at_top  out  1  frog reached row 0; held until reset_frog
- lives  out  2  remaining lives, 0..3
- reset_level  out  1  high while game over (lives == 0)

Behaviour:
- Decided: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values:
  - frog_x=START_X, frog_y=GRID_H-1, lives=3
  - frog_at_top=0, reset_level=0
  - state=PLAY, all switch-history registers=0, timer=0
- All outputs are registered. Latency is 1 cycle from the sampled input to the output change.
- Edge detect:
  - A move is a rising edge of a switch (current=1, previous=0).
  - History registers update every cycle in every state, so a switch held across a state change never produces a move.
- Move arbitration:
  - At most one move per cycle.
  - Priority sw1 > sw2 > sw3 > sw4.
  - If all four switches read 1 in the same cycle, no move (that is the level counter's global reset combo).
- Bounds:
  - Down at y=GRID_H-1, left at x=0 and right at x=GRID_W-1 are ignored. No wrap-around.
  - Up from y=1 sets y=0.
- States:
  - PLAY: moves accepted; collision honoured.
    - A move resulting in y=0: next cycle frog_y=0, frog_at_top=1, go to AT_TOP.
    - collision=1 (wins over a same-cycle move): lives-1, position=spawn.
      - If the old lives was 1: lives=0, reset_level=1, go to GAME_OVER.
      - Otherwise: load timer=RESPAWN_CYCLES-1, go to HIT.
  - AT_TOP: moves and collision ignored; frog_at_top held at 1.
  - HIT: moves and collision ignored; timer decrements. At timer==0 go to PLAY (or GRACE with the optional feature).
  - GAME_OVER: moves, collision and reset_frog ignored; lives=0 and reset_level=1 held.
- reset_lives and reset_frog are sampled every cycle. Priority: reset > reset_lives > reset_frog > collision > move.
  - reset_lives (any state): lives=3, reset_level=0, position=spawn, frog_at_top=0, timer=0, go to PLAY.
  - reset_frog (any state except GAME_OVER): position=spawn, frog_at_top=0, timer=0, go to PLAY. Lives are unchanged.
- lives never underflows: decrement only from ≥1. It never exceeds 3.
- Async reset mid-HIT or mid-GRACE clears the timer and the state immediately.

Optional Feature:
- Macro: FROG_GRACE_PERIOD_EN.
- Defined:
  - HIT exits to state GRACE, loading timer=GRACE_CYCLES-1.
  - GRACE behaves as PLAY (moves accepted, reaching the top goes to AT_TOP) but ignores collision.
  - At timer==0, go to PLAY.
  - reset_frog or reset_lives in GRACE goes to PLAY.
- Undefined: HIT exits directly to PLAY. No GRACE state or timer load; GRACE_CYCLES is unused.

Test Plan:
- Reset, then a single sw1 pulse → frog_x=10, frog_y=13 one cycle after the edge. Hold sw1 for 100 cycles → exactly one move.
- 14 sw1 edges → frog_y=0, frog_at_top=1 and held; further edges ignored. Pulse reset_frog → next cycle frog_y=14, frog_x=10, frog_at_top=0.
- At x=0, press sw3 → x stays 0. At x=19, press sw4 → x stays 19. At y=14, press sw2 → y stays 14.
- Assert collision in PLAY with lives=3 → lives=2, position=spawn. sw1 ignored for RESPAWN_CYCLES (set to 8 in the bench); a move is accepted on cycle 9.
- Three collisions → lives=0, reset_level=1. Moves and reset_frog ignored. Pulse reset_lives → lives=3, reset_level=0, state PLAY.
- Same cycle: sw1 edge + collision → collision wins (lives-1, spawn). All four switches rising together → no move. With FROG_GRACE_PERIOD_EN: a collision during GRACE leaves lives unchanged.
